// File: rtl/serial_cla_adder_pkg.sv
// Shared constants and FSM state type for the serial carry-lookahead adder.
package serial_cla_adder_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_cla_adder_cla4_slice.sv
// Combinational 4-bit carry-lookahead slice; c3_o is the carry into bit 3 (for overflow).
module serial_cla_adder_cla4_slice
  import serial_cla_adder_pkg::*;
(
  input  logic [SLICE_W-1:0] a_i,
  input  logic [SLICE_W-1:0] b_i,
  input  logic               cin_i,
  output logic [SLICE_W-1:0] s_o,
  output logic               c3_o,
  output logic               cout_o
);

  logic [SLICE_W-1:0] p;
  logic [SLICE_W-1:0] g;
  logic               c1, c2, c3, c4;

  assign p = a_i ^ b_i;
  assign g = a_i & b_i;

  // Every carry is formed directly from p/g and cin, not from the previous carry.
  assign c1 = g[0] | (p[0] & cin_i);
  assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin_i);
  assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
            | (p[2] & p[1] & p[0] & cin_i);
  assign c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
            | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin_i);

  assign s_o    = p ^ {c3, c2, c1, cin_i};
  assign c3_o   = c3;
  assign cout_o = c4;

endmodule

// File: rtl/serial_cla_adder.sv
// WIDTH-bit adder that reuses one 4-bit lookahead slice over WIDTH/4 cycles.
// Define SERIAL_CLA_OVF_EN to add the signed-overflow output ovf_o.
// states: IDLE | accept operands   RUN | one slice per cycle   DONE | hold result until taken
module serial_cla_adder
  import serial_cla_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
`ifdef SERIAL_CLA_OVF_EN
 ,output logic             ovf_o
`endif
);

  localparam int K     = WIDTH / SLICE_W;
  localparam int IDX_W = (K > 1) ? $clog2(K) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(K - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
`ifdef SERIAL_CLA_OVF_EN
  logic               ovf_q, ovf_d;
  logic               slice_c3;
`endif

  logic [SLICE_W-1:0] slice_a, slice_b, slice_s;
  logic               slice_cout;

  assign slice_a = a_q[SLICE_W*int'(idx_q) +: SLICE_W];
  assign slice_b = b_q[SLICE_W*int'(idx_q) +: SLICE_W];

  serial_cla_adder_cla4_slice u_slice (
    .a_i    (slice_a),
    .b_i    (slice_b),
    .cin_i  (carry_q),
    .s_o    (slice_s),
`ifdef SERIAL_CLA_OVF_EN
    .c3_o   (slice_c3),
`else
    .c3_o   (),
`endif
    .cout_o (slice_cout)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    idx_d   = idx_q;
`ifdef SERIAL_CLA_OVF_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          a_d     = a_i;
          b_d     = b_i;
          carry_d = cin_i;
          idx_d   = '0;
          sum_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[SLICE_W*int'(idx_q) +: SLICE_W] = slice_s;
        carry_d = slice_cout;
        // idx parks on the last slice instead of wrapping.
        if (idx_q == IDX_LAST) begin
          cout_d  = slice_cout;
`ifdef SERIAL_CLA_OVF_EN
          ovf_d   = slice_c3 ^ slice_cout;
`endif
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx_q   <= '0;
`ifdef SERIAL_CLA_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      idx_q   <= idx_d;
`ifdef SERIAL_CLA_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = (state_q == DONE);
  assign sum_o       = sum_q;
  assign cout_o      = cout_q;
`ifdef SERIAL_CLA_OVF_EN
  assign ovf_o       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_cla_adder.sv
// Self-checking bench for serial_cla_adder (WIDTH=16) against a plain-arithmetic model.
module tb_serial_cla_adder;

  localparam int W = 16;
  localparam int LAT = W / 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, out_valid, out_ready, cin, cout;
  logic [W-1:0] a, b, sum;
`ifdef SERIAL_CLA_OVF_EN
  logic         ovf;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  serial_cla_adder #(.WIDTH(W)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .a_i         (a),
    .b_i         (b),
    .cin_i       (cin),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .sum_o       (sum),
    .cout_o      (cout)
`ifdef SERIAL_CLA_OVF_EN
   ,.ovf_o       (ovf)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: full-precision add, then split into sum / carry / signed overflow.
  task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mc,
                       output logic [W-1:0] es, output logic ec, output logic eo);
    logic [W:0] full;
    full = {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mc};
    es   = full[W-1:0];
    ec   = full[W];
    eo   = (ma[W-1] == mb[W-1]) && (es[W-1] != ma[W-1]);
  endtask

  // Called just after the acceptance edge; counts edges until out_valid.
  task automatic wait_valid(input string tag);
    int lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, lat, LAT);
  endtask

  task automatic check_result(input string tag, input logic [W-1:0] ma,
                              input logic [W-1:0] mb, input logic mc);
    logic [W-1:0] es;
    logic         ec, eo;
    model(ma, mb, mc, es, ec, eo);
    chk({tag, "_sum"}, sum, es);
    chk({tag, "_cout"}, cout, ec);
`ifdef SERIAL_CLA_OVF_EN
    chk({tag, "_ovf"}, ovf, eo);
`endif
    chk({tag, "_in_ready_done"}, in_ready, 0);
  endtask

  task automatic handshake(input string tag);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_hs_out_valid"}, out_valid, 0);
    chk({tag, "_hs_in_ready"}, in_ready, 1);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  // Full transaction with optional back-pressure in DONE and junk inputs after acceptance.
  task automatic run_op(input string tag, input logic [W-1:0] ma, input logic [W-1:0] mb,
                        input logic mc, input int stall);
    logic [W-1:0] held_sum;
    logic         held_cout;
    @(negedge clk);
    a = ma; b = mb; cin = mc; in_valid = 1'b1; out_ready = 1'b0;
    chk({tag, "_in_ready_idle"}, in_ready, 1);
    @(posedge clk); #1;
    @(negedge clk);
    in_valid = 1'b0; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    #1;
    wait_valid(tag);
    check_result(tag, ma, mb, mc);
    held_sum  = sum;
    held_cout = cout;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      in_valid = 1'($urandom); a = W'($urandom); b = W'($urandom);
      @(posedge clk); #1;
      chk({tag, "_stall_valid"}, out_valid, 1);
      chk({tag, "_stall_sum"}, sum, held_sum);
      chk({tag, "_stall_cout"}, cout, held_cout);
      chk({tag, "_stall_in_ready"}, in_ready, 0);
    end
    handshake(tag);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
`ifdef SERIAL_CLA_OVF_EN
    chk("rst_ovf", ovf, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    run_op("basic", 16'h1234, 16'h4321, 1'b0, 0);
    run_op("ripple", 16'hFFFF, 16'h0000, 1'b1, 0);
    run_op("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 0);
    run_op("wrap", 16'hFFFF, 16'h0001, 1'b0, 3);

    // Reset mid-RUN (idx=2) after a result that left cout=1.
    @(negedge clk);
    a = 16'hABCD; b = 16'h9876; cin = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_sum", sum, 0);
    chk("midrst_cout", cout, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      chk("midrst_no_output", out_valid, 0);
    end
    run_op("after_rst", 16'h00FF, 16'h0001, 1'b0, 0);

    // in_valid held high across two operand sets.
    @(negedge clk);
    a = 16'h0001; b = 16'h0002; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    a = 16'h8000; b = 16'h8000;
    #1;
    wait_valid("b2b1");
    check_result("b2b1", 16'h0001, 16'h0002, 1'b0);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("b2b_hs_in_ready", in_ready, 1);
    chk("b2b_hs_out_valid", out_valid, 0);
    @(negedge clk);
    out_ready = 1'b0;
    @(posedge clk); #1;
    chk("b2b_second_accept", in_ready, 0);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    wait_valid("b2b2");
    check_result("b2b2", 16'h8000, 16'h8000, 1'b0);
    handshake("b2b2");

    for (int n = 0; n < 40; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      if (n % 8 == 0) rb = ~ra;
      run_op("rand", ra, rb, 1'($urandom), int'($urandom_range(0, 2)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_cla_adder.md
# serial_cla_adder

Multi-cycle wide adder that feeds operands four bits per cycle through a 4-bit carry-lookahead slice and chains the carry through a register. It sits directly upstream of the 4-bit lookahead adder datapath: it owns the handshake, slicing and carry sequencing, so WIDTH-bit additions reuse one 4-bit lookahead slice instead of a full-width adder. Results are returned on a valid/ready output port.

## Interface
- WIDTH, 16, operand and sum width in bits; must be a multiple of 4, minimum 4.
- clk  input  1  rising-edge clock; the block's single clock.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  operand request valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A, unsigned or two's complement.
- b  input  WIDTH  operand B.
- cin  input  1  carry into bit 0.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  a+b+cin modulo 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1.
- ovf  output  1  signed overflow; present only with SERIAL_CLA_OVF_EN.

## Operation
- K = WIDTH/4 slices; slice i covers bits [4i+3:4i].
- FSM states IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready: latch a, b; carry reg <= cin; idx <= 0; sum reg <= 0; -> RUN.
- RUN: in_ready=0, out_valid=0. Each cycle: slice idx of a, b and carry reg drive the 4-bit lookahead slice; sum[slice idx] <= slice sum; carry reg <= slice cout; idx <= idx+1. When idx==K-1: cout <= slice cout, -> DONE.
- DONE: out_valid=1; sum, cout (and ovf) held stable. On out_ready: -> IDLE. in_valid ignored.
- idx counter width clog2(K), minimum 1; it never wraps in operation (exits at K-1).
- Arithmetic is modulo 2^WIDTH; cout is the true carry of the full-width add.
- Operand registers are not updated outside IDLE acceptance; input changes during RUN/DONE have no effect.
- Simultaneous in_valid and out_ready in DONE: result handshake completes, operands not accepted that cycle (in_ready=0).

## Timing
- Reset (rst_n low at a rising edge): state IDLE, in_ready=1, out_valid=0, sum=0, cout=0, ovf=0, idx=0, carry reg=0. Applies in any state; an operation in flight is discarded with no output.
- Acceptance edge E0; out_valid is high after edge E_K (K edges later; 4 for WIDTH=16).
- Result handshake edge: next cycle state IDLE, in_ready=1.
- Minimum throughput: one addition per K+2 cycles (accept, K RUN, handshake in DONE; next accept one cycle after).
- in_ready is a pure function of state (no combinational path from out_ready).

## Configuration
- SERIAL_CLA_OVF_EN defined: port ovf exists; on last RUN cycle ovf <= (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1); held with sum; reset 0.
- Undefined: no ovf port, no related logic; all other behaviour identical.

## Structure
- Shared package: SLICE_W = 4 constant; FSM state enum (IDLE, RUN, DONE).
- One sub-module: cla4_slice — combinational 4-bit carry-lookahead (p = a^b, g = a&b, explicit lookahead carries c1..c4, s = p ^ {c3,c2,c1,cin}), outputs s[3:0], c3 (carry into bit 3, for ovf) and cout. Instantiated once, muxed by idx.

## Test plan
- WIDTH=16, a=0x1234, b=0x4321, cin=0 -> sum=0x5555, cout=0, out_valid high exactly 4 edges after acceptance.
- a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1 (carry ripples through all 4 slices via carry reg).
- a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1 with SERIAL_CLA_OVF_EN; a=0xFFFF, b=0x0001 -> sum=0x0000, cout=1, ovf=0.
- Back-pressure: out_ready low 3 cycles in DONE -> out_valid, sum, cout stable, in_ready=0, in_valid pulses ignored; handshake on 4th cycle -> in_ready=1 next cycle.
- rst_n low for one edge while idx=2 in RUN -> next cycle IDLE, in_ready=1, out_valid=0, sum=0, cout=0; subsequent op a=0x00FF, b=0x0001 -> sum=0x0100, cout=0.
- in_valid held high with two operand sets (0x0001+0x0002, then 0x8000+0x8000) -> results 0x0003/cout=0 then 0x0000/cout=1, second accepted one cycle after first result handshake.
